conv_operand_loader: RTL and testbench

Serial-to-parallel operand feeder for the 2×4×4 convolution engine. Accepts a 4-bit nibble stream over a valid/ready handshake and packs each group of 32 nibbles into a 128-bit vector. Each full group drives the engine's weight_valid or in_valid port as a one-cycle pulse. Enforces a hold-off after every IFM issue so the engine's 52-cycle run is never disturbed by new IFM or weight data.

---
 rtl/conv_pkg.sv | 10 +
 rtl/conv_operand_loader_if.sv | 28 ++
 rtl/conv_holdoff_timer.sv | 24 ++
 rtl/conv_operand_loader.sv | 91 +++++++++
 tb/tb_conv_operand_loader.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/conv_pkg.sv
// Shared constants and types for the 2x4x4 convolution engine and its operand loader.
package conv_pkg;
  localparam int DW          = 4;
  localparam int N_ELEM      = 32;
  localparam int OFM_W       = 13;
  localparam int HOLDOFF_DEF = 53;
  localparam int IDX_W       = 5;

  typedef enum logic {FILL = 1'b0, WAIT = 1'b1} ld_state_e;
endpackage

// File: rtl/conv_operand_loader_if.sv
// Nibble stream in, packed weight/IFM vectors and status out.
interface conv_operand_loader_if
  import conv_pkg::*;
#(
  parameter int W  = DW,
  parameter int NE = N_ELEM
);
  logic            s_valid;
  logic            s_ready;
  logic [W-1:0]    s_data;
  logic            s_wsel;
  logic [NE*W-1:0] weight_bus;
  logic [NE*W-1:0] ifm_bus;
  logic            weight_valid;
  logic            in_valid;
  logic            busy;
  logic            protocol_err;

  modport master (
    output s_valid, s_data, s_wsel,
    input  s_ready, weight_bus, ifm_bus, weight_valid, in_valid, busy, protocol_err
  );

  modport slave (
    input  s_valid, s_data, s_wsel,
    output s_ready, weight_bus, ifm_bus, weight_valid, in_valid, busy, protocol_err
  );
endinterface

// File: rtl/conv_holdoff_timer.sv
// Down-counter guarding the engine's run after each IFM issue; reload wins over decrement.
module conv_holdoff_timer
  import conv_pkg::*;
#(
  parameter int HOLDOFF = HOLDOFF_DEF,
  localparam int CW     = $clog2(HOLDOFF + 1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_load,
  output logic o_busy,
  output logic o_zero
);
  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)            r_cnt <= '0;
    else if (i_load)       r_cnt <= CW'(HOLDOFF);
    else if (r_cnt != '0)  r_cnt <= r_cnt - 1'b1;
  end

  assign o_busy = (r_cnt != '0);
  assign o_zero = ~o_busy;
endmodule

// File: rtl/conv_operand_loader.sv
// Packs 32 nibbles into a 128-bit weight or IFM vector and issues it as a one-cycle
// pulse, stalling issues while the engine is still running on the previous IFM.
module conv_operand_loader
  import conv_pkg::*;
#(
  parameter int DW_P    = DW,
  parameter int NE_P    = N_ELEM,
  parameter int HOLDOFF = HOLDOFF_DEF,
  localparam int IW     = $clog2(NE_P)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  conv_operand_loader_if.slave  bus
);
  ld_state_e                  r_state;
  logic [IW-1:0]              r_idx;
  logic                       r_grp_wgt;
  logic                       r_perr;
  logic                       r_wv;
  logic                       r_iv;
  logic [NE_P-1:0][DW_P-1:0]  r_shadow;
  logic [NE_P*DW_P-1:0]       r_wbus;
  logic [NE_P*DW_P-1:0]       r_ibus;

  logic w_xfer;
  logic w_issue;
  logic w_hold_busy;
  logic w_hold_zero;

  assign w_xfer  = bus.s_valid && (r_state == FILL);
  assign w_issue = (r_state == WAIT) && w_hold_zero;

  // Only IFM issues start an engine run, so only they arm the hold-off.
  conv_holdoff_timer #(.HOLDOFF(HOLDOFF)) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_load (w_issue && !r_grp_wgt),
    .o_busy (w_hold_busy),
    .o_zero (w_hold_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= FILL;
      r_idx     <= '0;
      r_grp_wgt <= 1'b0;
      r_perr    <= 1'b0;
      r_wv      <= 1'b0;
      r_iv      <= 1'b0;
      r_shadow  <= '0;
      r_wbus    <= '0;
      r_ibus    <= '0;
    end else begin
      r_wv <= 1'b0;
      r_iv <= 1'b0;
      case (r_state)
        FILL: if (w_xfer) begin
          r_shadow[r_idx] <= bus.s_data;
          // Group type is latched on element 0; later mismatches are flagged, not obeyed.
          if (r_idx == '0)                  r_grp_wgt <= bus.s_wsel;
          else if (bus.s_wsel != r_grp_wgt) r_perr    <= 1'b1;
          if (r_idx == IW'(NE_P - 1)) begin
            r_idx   <= '0;
            r_state <= WAIT;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        WAIT: if (w_hold_zero) begin
          if (r_grp_wgt) begin
            r_wbus <= r_shadow;
            r_wv   <= 1'b1;
          end else begin
            r_ibus <= r_shadow;
            r_iv   <= 1'b1;
          end
          r_state <= FILL;
        end
        default: r_state <= FILL;
      endcase
    end
  end

  assign bus.s_ready      = (r_state == FILL);
  assign bus.weight_bus   = r_wbus;
  assign bus.ifm_bus      = r_ibus;
  assign bus.weight_valid = r_wv;
  assign bus.in_valid     = r_iv;
  assign bus.busy         = w_hold_busy;
  assign bus.protocol_err = r_perr;
endmodule

// File: tb/tb_conv_operand_loader.sv
// Scoreboard bench: the driver records each completed group with its last-accept edge;
// the monitor derives when and what must be issued and checks every cycle.
module tb_conv_operand_loader;
  localparam int NE  = 32;
  localparam int HO  = 53;
  localparam int BW  = 128;
  localparam int NEV = 32'h7fffffff;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  conv_operand_loader_if u_if ();

  conv_operand_loader u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (u_if)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int nchk = 0;
  int nerr = 0;

  typedef struct {
    bit            wgt;
    logic [BW-1:0] data;
    int            acc;
  } grp_t;
  grp_t sbq[$];

  int            d_idx     = 0;
  bit            d_grp     = 1'b0;
  logic [BW-1:0] d_vec     = '0;
  int            perr_edge = NEV;

  int            last_ifm = -1000;
  logic [BW-1:0] m_wbus   = '0;
  logic [BW-1:0] m_ibus   = '0;

  task automatic chk(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s cyc=%0d got %h expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic finish_run();
    $display("CHECKS %0d ERRORS %0d", nchk, nerr);
    $finish;
  endtask

  // Call at a negedge; returns at the negedge after the nibble was accepted.
  task automatic send(input logic [3:0] d, input bit w);
    int guard = 0;
    u_if.s_valid = 1'b1;
    u_if.s_data  = d;
    u_if.s_wsel  = w;
    while (!u_if.s_ready) begin
      @(negedge clk);
      guard++;
      if (guard > 500) begin
        nchk++; nerr++;
        $display("FAIL ready_timeout cyc=%0d got s_ready=0 expected 1 within 500 cycles", cyc);
        $display("CHECKS %0d ERRORS %0d", nchk, nerr);
        $fatal(1);
      end
    end
    if (d_idx == 0) d_grp = w;
    else if (w != d_grp && perr_edge == NEV) perr_edge = cyc + 1;
    d_vec[d_idx*4 +: 4] = d;
    if (d_idx == NE - 1) begin
      sbq.push_back('{d_grp, d_vec, cyc + 1});
      d_idx = 0;
    end else begin
      d_idx++;
    end
    @(negedge clk);
    u_if.s_valid = 1'b0;
  endtask

  task automatic drain();
    int guard = 0;
    while (sbq.size() != 0 && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    nchk++;
    if (sbq.size() != 0) begin
      nerr++;
      $display("FAIL drain cyc=%0d got %0d pending groups expected 0", cyc, sbq.size());
      sbq.delete();
    end
  endtask

  task automatic check_reset_outputs();
    chk("rst_s_ready",  128'(u_if.s_ready), 128'(1));
    chk("rst_wv",       128'(u_if.weight_valid), 128'(0));
    chk("rst_iv",       128'(u_if.in_valid), 128'(0));
    chk("rst_busy",     128'(u_if.busy), 128'(0));
    chk("rst_perr",     128'(u_if.protocol_err), 128'(0));
    chk("rst_wbus",     u_if.weight_bus, '0);
    chk("rst_ibus",     u_if.ifm_bus, '0);
  endtask

  // Monitor: an issue is due one edge after the last accept, but no earlier than
  // HOLDOFF+1 edges after the previous IFM issue.
  always @(negedge clk) begin
    int   c, ex;
    grp_t e;
    c = cyc;
    if (!rst_n) begin
      last_ifm = -1000;
      m_wbus   = '0;
      m_ibus   = '0;
    end else begin
      if (u_if.weight_valid && u_if.in_valid) begin
        nchk++; nerr++;
        $display("FAIL both_valid cyc=%0d got both pulses expected at most one", c);
      end
      if (u_if.weight_valid || u_if.in_valid) begin
        if (sbq.size() == 0) begin
          nchk++; nerr++;
          $display("FAIL spurious_valid cyc=%0d got wv=%0b iv=%0b expected none", c,
                   u_if.weight_valid, u_if.in_valid);
        end else begin
          e  = sbq.pop_front();
          ex = (e.acc + 1 > last_ifm + HO + 1) ? e.acc + 1 : last_ifm + HO + 1;
          chk("issue_cycle", 128'(c), 128'(ex));
          chk("issue_is_wgt", 128'(u_if.weight_valid), 128'(e.wgt));
          if (e.wgt) m_wbus = e.data;
          else begin
            m_ibus   = e.data;
            last_ifm = c;
          end
        end
      end else if (sbq.size() != 0) begin
        ex = (sbq[0].acc + 1 > last_ifm + HO + 1) ? sbq[0].acc + 1 : last_ifm + HO + 1;
        if (c > ex) begin
          nchk++; nerr++;
          $display("FAIL issue_missing cyc=%0d got no pulse expected one at %0d", c, ex);
          e = sbq.pop_front();
          if (e.wgt) m_wbus = e.data;
          else begin
            m_ibus   = e.data;
            last_ifm = ex;
          end
        end
      end
      if (sbq.size() != 0 && c >= sbq[0].acc)
        chk("s_ready_in_wait", 128'(u_if.s_ready), 128'(0));
      chk("weight_bus", u_if.weight_bus, m_wbus);
      chk("ifm_bus", u_if.ifm_bus, m_ibus);
      chk("busy", 128'(u_if.busy), 128'((c >= last_ifm) && (c - last_ifm <= HO - 1)));
      chk("protocol_err", 128'(u_if.protocol_err), 128'(c >= perr_edge));
    end
  end

  initial begin
    u_if.s_valid = 1'b0;
    u_if.s_data  = '0;
    u_if.s_wsel  = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs();
    rst_n = 1'b1;
    @(negedge clk);

    // Weight ramp: element k = k mod 16.
    for (int k = 0; k < NE; k++) send(4'(k % 16), 1'b1);
    drain();
    chk("ramp_weight_bus", m_wbus, 128'hFEDCBA9876543210_FEDCBA9876543210);

    // Back-to-back IFM groups.
    for (int k = 0; k < NE; k++) send(4'h3, 1'b0);
    for (int k = 0; k < NE; k++) send(4'h5, 1'b0);
    drain();
    chk("ifm5_bus", u_if.ifm_bus, {32{4'h5}});

    // IFM followed immediately by a weight group.
    for (int k = 0; k < NE; k++) send(4'($urandom_range(15)), 1'b0);
    for (int k = 0; k < NE; k++) send(4'($urandom_range(15)), 1'b1);
    drain();

    // Valid alternating 1/0.
    for (int k = 0; k < NE; k++) begin
      send(4'($urandom_range(15)), 1'b0);
      @(negedge clk);
    end
    drain();

    // Select toggles at element 10 of an IFM group.
    for (int k = 0; k < NE; k++) send(4'($urandom_range(15)), k == 10);
    drain();

    // Reset during hold-off with a partial group in flight.
    for (int k = 0; k < NE; k++) send(4'($urandom_range(15)), 1'b0);
    drain();
    for (int k = 0; k < 10; k++) send(4'($urandom_range(15)), 1'b1);
    #2 rst_n = 1'b0;
    sbq.delete();
    d_idx     = 0;
    perr_edge = NEV;
    #1 check_reset_outputs();
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    for (int k = 0; k < NE; k++) send(4'($urandom_range(15)), 1'b1);
    drain();

    // Random groups, types and gaps.
    for (int g = 0; g < 6; g++) begin
      bit w;
      w = 1'($urandom_range(1));
      for (int k = 0; k < NE; k++) begin
        send(4'($urandom_range(15)), w);
        if ($urandom_range(3) == 0) @(negedge clk);
      end
    end
    drain();
    repeat (HO + 5) @(negedge clk);
    finish_run();
  end
endmodule
